imem_loader: RTL and testbench

Boot-time instruction memory writer for the G9 single-cycle core. It receives a byte stream over a valid/ready handshake, packs the bytes into 32-bit words, and writes them through the write port of InstructionMemory (`wea`/`addra`/`dina`); the core only reads that memory. While a load is in progress the block holds the processor in reset, and it releases the processor once the last word has been written, so execution starts at PC 0 on a freshly loaded program.

---
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and InstructionMemory write-port bundle for imem_loader.
// The master side feeds bytes and observes status; the slave side is the loader.
interface imem_loader_if #(
    parameter int unsigned size = 32
);
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wea;
    logic [size-1:0]   addra;
    logic [size-1:0]   dina;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [15:0]       words_loaded;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, wea, addra, dina, cpu_hold, done, error, words_loaded
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, wea, addra, dina, cpu_hold, done, error, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: packs a big-endian byte stream into 32-bit words and writes
// them into InstructionMemory, holding the core in reset until the load finishes.
module imem_loader #(
    parameter int unsigned MEM_SIZE = 512,
    parameter int unsigned size     = 32
) (
    input logic          clk,
    input logic          reset,
    imem_loader_if.slave bus
);

    localparam logic [2:0] HDR_HI = 3'd0;
    localparam logic [2:0] HDR_LO = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] FLUSH  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] ERROR  = 3'd5;

    localparam logic [15:0] MEM_WORDS = 16'(MEM_SIZE);

    logic [2:0]      state;
    logic [15:0]     cnt;
    logic [1:0]      byte_idx;
    logic [15:0]     word_idx;
    logic [23:0]     word_asm;
    logic [15:0]     words_loaded_q;
    logic            wea_q;
    logic [size-1:0] addra_q;
    logic [size-1:0] dina_q;
    logic            cpu_hold_q;
    logic            done_q;
    logic            error_q;

    logic            in_ready;
    logic            xfer;
    logic [15:0]     hdr_n;
    logic            last_word;

    always_comb begin
        in_ready  = !reset && ((state == HDR_HI) || (state == HDR_LO) || (state == DATA));
        xfer      = bus.in_valid && in_ready;
        hdr_n     = {cnt[15:8], bus.in_data};
        last_word = (word_idx == (cnt - 16'd1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= HDR_HI;
            cnt            <= '0;
            byte_idx       <= '0;
            word_idx       <= '0;
            word_asm       <= '0;
            words_loaded_q <= '0;
            wea_q          <= 1'b0;
            addra_q        <= '0;
            dina_q         <= '0;
            cpu_hold_q     <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            wea_q <= 1'b0;
            case (state)
                HDR_HI: begin
                    if (xfer) begin
                        cnt[15:8] <= bus.in_data;
                        state     <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        cnt[7:0] <= bus.in_data;
                        // Size is checked here so no write can ever address beyond MEM_SIZE.
                        if (hdr_n == 16'd0) begin
                            state      <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else if (hdr_n > MEM_WORDS) begin
                            state   <= ERROR;
                            error_q <= 1'b1;
                        end else begin
                            state    <= DATA;
                            byte_idx <= '0;
                            word_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
                        word_asm <= {word_asm[15:0], bus.in_data};
                        if (byte_idx == 2'd3) begin
                            wea_q          <= 1'b1;
                            addra_q        <= {{(size-16){1'b0}}, word_idx};
                            dina_q         <= {word_asm, bus.in_data};
                            word_idx       <= word_idx + 16'd1;
                            words_loaded_q <= words_loaded_q + 16'd1;
                            if (last_word) begin
                                state <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    // The last write pulse is on the bus during this cycle; release the core after it.
                    state      <= DONE;
                    done_q     <= 1'b1;
                    cpu_hold_q <= 1'b0;
                end
                DONE: begin
                    if (bus.start) begin
                        state          <= HDR_HI;
                        done_q         <= 1'b0;
                        cpu_hold_q     <= 1'b1;
                        words_loaded_q <= '0;
                        byte_idx       <= '0;
                        word_idx       <= '0;
                    end
                end
                ERROR: begin
                    error_q    <= 1'b1;
                    cpu_hold_q <= 1'b1;
                end
                default: begin
                    state <= HDR_HI;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.wea          = wea_q;
    assign bus.addra        = addra_q;
    assign bus.dina         = dina_q;
    assign bus.cpu_hold     = cpu_hold_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table for the main loads,
// plus hand-written sequences for mid-load reset and stalled streams.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    imem_loader_if #(.size(32)) bus ();

    imem_loader #(
        .MEM_SIZE(512),
        .size(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        st;
        logic        e_wea;
        logic [31:0] e_addr;
        logic [31:0] e_dina;
        logic        e_ready;
        logic        e_done;
        logic        e_hold;
        logic        e_err;
        logic [15:0] e_wl;
    } vec_t;

    vec_t vt[$];

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned wr_count = 0;
    logic [31:0] mem_model [0:15];

    // Write-port observer, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.wea === 1'b1) begin
            mem_model[bus.addra[3:0]] = bus.dina;
            wr_count = wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic st);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.start    = st;
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic v, input logic [7:0] d, input logic st,
                        input logic wea, input logic [31:0] addr, input logic [31:0] dina,
                        input logic rdy, input logic dn, input logic hold, input logic err,
                        input logic [15:0] wl);
        vec_t r;
        r.v = v; r.d = d; r.st = st; r.e_wea = wea; r.e_addr = addr; r.e_dina = dina;
        r.e_ready = rdy; r.e_done = dn; r.e_hold = hold; r.e_err = err; r.e_wl = wl;
        vt.push_back(r);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " wea"},      {31'd0, bus.wea},      32'd0);
        chk({tag, " addra"},    bus.addra,             32'd0);
        chk({tag, " dina"},     bus.dina,              32'd0);
        chk({tag, " cpu_hold"}, {31'd0, bus.cpu_hold}, 32'd1);
        chk({tag, " done"},     {31'd0, bus.done},     32'd0);
        chk({tag, " error"},    {31'd0, bus.error},    32'd0);
        chk({tag, " wl"},       {16'd0, bus.words_loaded}, 32'd0);
        chk({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    endtask

    logic [7:0] stall_bytes [0:9];
    logic [7:0] mid_bytes   [0:6];
    logic [7:0] one_bytes   [0:5];
    int unsigned wr_before;

    initial begin
        stall_bytes = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
        mid_bytes   = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
        one_bytes   = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};

        // Load 00 02 DEADBEEF 12345678 back to back.
        addv(1, 8'h00, 0, 0, 0, 0,             1, 0, 1, 0, 16'd0);
        addv(1, 8'h02, 0, 0, 0, 0,             1, 0, 1, 0, 16'd0);
        addv(1, 8'hDE, 0, 0, 0, 0,             1, 0, 1, 0, 16'd0);
        addv(1, 8'hAD, 0, 0, 0, 0,             1, 0, 1, 0, 16'd0);
        addv(1, 8'hBE, 0, 0, 0, 0,             1, 0, 1, 0, 16'd0);
        addv(1, 8'hEF, 0, 1, 0, 32'hDEADBEEF,  1, 0, 1, 0, 16'd1);
        addv(1, 8'h12, 0, 0, 0, 0,             1, 0, 1, 0, 16'd1);
        addv(1, 8'h34, 0, 0, 0, 0,             1, 0, 1, 0, 16'd1);
        addv(1, 8'h56, 0, 0, 0, 0,             1, 0, 1, 0, 16'd1);
        addv(1, 8'h78, 0, 1, 1, 32'h12345678,  0, 0, 1, 0, 16'd2);
        addv(0, 8'h00, 0, 0, 0, 0,             0, 1, 0, 0, 16'd2);
        addv(1, 8'hFF, 0, 0, 0, 0,             0, 1, 0, 0, 16'd2);
        // Restart and load 00 01 CAFEBABE with a stray start during DATA.
        addv(0, 8'h00, 1, 0, 0, 0,             1, 0, 1, 0, 16'd0);
        addv(1, 8'h00, 0, 0, 0, 0,             1, 0, 1, 0, 16'd0);
        addv(1, 8'h01, 0, 0, 0, 0,             1, 0, 1, 0, 16'd0);
        addv(1, 8'hCA, 1, 0, 0, 0,             1, 0, 1, 0, 16'd0);
        addv(1, 8'hFE, 0, 0, 0, 0,             1, 0, 1, 0, 16'd0);
        addv(1, 8'hBA, 0, 0, 0, 0,             1, 0, 1, 0, 16'd0);
        addv(1, 8'hBE, 0, 1, 0, 32'hCAFEBABE,  0, 0, 1, 0, 16'd1);
        addv(0, 8'h00, 0, 0, 0, 0,             0, 1, 0, 0, 16'd1);
        // Zero-length load.
        addv(0, 8'h00, 1, 0, 0, 0,             1, 0, 1, 0, 16'd0);
        addv(1, 8'h00, 0, 0, 0, 0,             1, 0, 1, 0, 16'd0);
        addv(1, 8'h00, 0, 0, 0, 0,             0, 1, 0, 0, 16'd0);
        // Oversize header 0x0201 = 513.
        addv(0, 8'h00, 1, 0, 0, 0,             1, 0, 1, 0, 16'd0);
        addv(1, 8'h02, 0, 0, 0, 0,             1, 0, 1, 0, 16'd0);
        addv(1, 8'h01, 0, 0, 0, 0,             0, 0, 1, 1, 16'd0);
        addv(1, 8'h55, 1, 0, 0, 0,             0, 0, 1, 1, 16'd0);
        addv(0, 8'h00, 0, 0, 0, 0,             0, 0, 1, 1, 16'd0);

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.start    = 1'b0;
        reset        = 1'b1;
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 0);
        chk_reset_vals("por");
        reset = 1'b0;
        #1;
        chk("por in_ready after release", {31'd0, bus.in_ready}, 32'd1);

        foreach (vt[i]) begin
            cyc(vt[i].v, vt[i].d, vt[i].st);
            chk($sformatf("v%0d wea", i),      {31'd0, bus.wea},      {31'd0, vt[i].e_wea});
            chk($sformatf("v%0d in_ready", i), {31'd0, bus.in_ready}, {31'd0, vt[i].e_ready});
            chk($sformatf("v%0d done", i),     {31'd0, bus.done},     {31'd0, vt[i].e_done});
            chk($sformatf("v%0d cpu_hold", i), {31'd0, bus.cpu_hold}, {31'd0, vt[i].e_hold});
            chk($sformatf("v%0d error", i),    {31'd0, bus.error},    {31'd0, vt[i].e_err});
            chk($sformatf("v%0d wl", i),       {16'd0, bus.words_loaded}, {16'd0, vt[i].e_wl});
            if (vt[i].e_wea) begin
                chk($sformatf("v%0d addra", i), bus.addra, vt[i].e_addr);
                chk($sformatf("v%0d dina", i),  bus.dina,  vt[i].e_dina);
            end
        end
        chk("table write count", wr_count, 32'd3);

        // Reset mid-word: the written word survives, everything else reinitialises.
        reset = 1'b1;
        cyc(0, 8'h00, 0);
        chk_reset_vals("err reset");
        reset = 1'b0;
        foreach (mid_bytes[i]) cyc(1, mid_bytes[i], 0);
        chk("mid word0", mem_model[0], 32'hAABBCCDD);
        reset = 1'b1;
        cyc(1, 8'h22, 0);
        chk_reset_vals("mid reset");
        reset = 1'b0;
        wr_before = wr_count;
        foreach (one_bytes[i]) begin
            cyc(1, one_bytes[i], 0);
            if (i == 5) begin
                chk("post-reset wea",   {31'd0, bus.wea}, 32'd1);
                chk("post-reset addra", bus.addra, 32'd0);
                chk("post-reset dina",  bus.dina,  32'h01020304);
            end
        end
        cyc(0, 8'h00, 0);
        chk("post-reset done",   {31'd0, bus.done}, 32'd1);
        chk("post-reset writes", wr_count - wr_before, 32'd1);

        // Stalled stream: 3 idle cycles after every byte.
        cyc(0, 8'h00, 1);
        wr_before = wr_count;
        foreach (stall_bytes[i]) begin
            cyc(1, stall_bytes[i], 0);
            if (i == 5) begin
                chk("stall w0 wea",   {31'd0, bus.wea}, 32'd1);
                chk("stall w0 addra", bus.addra, 32'd0);
                chk("stall w0 dina",  bus.dina,  32'hDEADBEEF);
            end else if (i == 9) begin
                chk("stall w1 wea",   {31'd0, bus.wea}, 32'd1);
                chk("stall w1 addra", bus.addra, 32'd1);
                chk("stall w1 dina",  bus.dina,  32'h12345678);
            end else begin
                chk($sformatf("stall b%0d wea", i), {31'd0, bus.wea}, 32'd0);
            end
            if (i < 9) begin
                for (int k = 0; k < 3; k++) begin
                    cyc(0, 8'hEE, 0);
                    chk($sformatf("stall b%0d gap%0d wea", i, k), {31'd0, bus.wea}, 32'd0);
                end
                chk($sformatf("stall b%0d ready", i), {31'd0, bus.in_ready}, 32'd1);
            end
        end
        cyc(0, 8'h00, 0);
        chk("stall done",     {31'd0, bus.done},     32'd1);
        chk("stall cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
        chk("stall wl",       {16'd0, bus.words_loaded}, 32'd2);
        chk("stall writes",   wr_count - wr_before, 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
